// File: rtl/mod_393_interval_arbiter.sv
// mod_393_interval_arbiter
// Two-requester round-robin arbiter that times each granted interval with
// an external 4-bit 393-type counter section. The arbiter clears the
// counter, clocks it with CCLK (the counter advances on the falling edge),
// and reads the count back on Q until it equals the winner's latched length.
//
// Parameters:
//   HALF   CLK cycles per CCLK phase (1..8)
// Ports:
//   CLK    clock, rising edge
//   CLR    synchronous active-high reset
//   REQ    [1:0] level requests, bit i = requester i
//   LEN0/1 [3:0] interval length in counts, 0 means 16
//   Q      [3:0] counter readback
//   CCLK   counter clock
//   CCLR   counter clear, active high
//   GNT    [1:0] one-hot grant, held for the interval
//   DONE   [1:0] one-cycle completion pulse
//   FAULT  sticky watchdog flag
// Optional feature macro: MOD_393_WATCHDOG_EN (watchdog on missing match).

module mod_393_interval_arbiter #(
    parameter int unsigned HALF = 1
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic [1:0] REQ,
    input  logic [3:0] LEN0,
    input  logic [3:0] LEN1,
    input  logic [3:0] Q,
    output logic       CCLK,
    output logic       CCLR,
    output logic [1:0] GNT,
    output logic [1:0] DONE,
    output logic       FAULT
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_LO,
        S_HI,
        S_FIN
    } state_t;

    localparam int unsigned PW = 3;
    localparam logic [PW-1:0] PH_LAST = PW'(HALF - 1);

`ifdef MOD_393_WATCHDOG_EN
    localparam int unsigned WD_LIMIT = 2 * HALF * 17 + 2;
    localparam int unsigned WDW      = $clog2(WD_LIMIT);
    localparam logic [WDW-1:0] WD_LAST = WDW'(WD_LIMIT - 1);
`endif

    state_t          state_q;
    logic [3:0]      t_q;
    logic            g_q;
    logic            last_q;
    logic [PW-1:0]   ph_q;
    logic            match_q;
    logic            cclk_q;
    logic            cclr_q;
    logic [1:0]      gnt_q;
    logic [1:0]      done_q;

`ifdef MOD_393_WATCHDOG_EN
    logic [WDW-1:0]  wd_q;
    logic            fault_q;
`endif

    logic win;
    logic req_g;
    logic active;
    logic q_match;
    logic hi_match;

    // Round-robin pick: on a tie the requester not served last wins
    assign win      = (REQ == 2'b11) ? ~last_q : REQ[1];
    assign req_g    = REQ[g_q];
    assign active   = (state_q == S_ARM) || (state_q == S_LO) || (state_q == S_HI);
    // Length 0 (=16) matches once the counter wraps back to 0
    assign q_match  = (Q == t_q);
    // Compare result is taken in the first HI cycle only
    assign hi_match = (ph_q == '0) ? q_match : match_q;

    // Control FSM with registered outputs
    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q <= S_IDLE;
            t_q     <= 4'd0;
            g_q     <= 1'b0;
            last_q  <= 1'b1;
            ph_q    <= '0;
            match_q <= 1'b0;
            cclk_q  <= 1'b1;
            cclr_q  <= 1'b1;
            gnt_q   <= 2'b00;
            done_q  <= 2'b00;
`ifdef MOD_393_WATCHDOG_EN
            wd_q    <= '0;
            fault_q <= 1'b0;
`endif
        end else begin
            done_q <= 2'b00;
            if (active && !req_g) begin
                // Granted requester withdrew: abandon the interval silently
                state_q <= S_IDLE;
                gnt_q   <= 2'b00;
                cclr_q  <= 1'b1;
                cclk_q  <= 1'b1;
                ph_q    <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        cclk_q <= 1'b1;
                        cclr_q <= 1'b1;
                        gnt_q  <= 2'b00;
                        if (REQ != 2'b00) begin
                            g_q     <= win;
                            last_q  <= win;
                            t_q     <= win ? LEN1 : LEN0;
                            gnt_q   <= win ? 2'b10 : 2'b01;
                            cclr_q  <= 1'b0;
                            state_q <= S_ARM;
`ifdef MOD_393_WATCHDOG_EN
                            wd_q    <= '0;
`endif
                        end
                    end
                    S_ARM: begin
                        state_q <= S_LO;
                        cclk_q  <= 1'b0;
                        ph_q    <= '0;
                    end
                    S_LO: begin
                        if (ph_q == PH_LAST) begin
                            state_q <= S_HI;
                            cclk_q  <= 1'b1;
                            ph_q    <= '0;
                        end else begin
                            ph_q <= ph_q + PW'(1);
                        end
                    end
                    S_HI: begin
                        if (ph_q == '0) begin
                            match_q <= q_match;
                        end
                        if (ph_q == PH_LAST) begin
                            ph_q <= '0;
                            if (hi_match) begin
                                state_q <= S_FIN;
                                done_q  <= g_q ? 2'b10 : 2'b01;
                                gnt_q   <= 2'b00;
                                cclr_q  <= 1'b1;
                            end else begin
                                state_q <= S_LO;
                                cclk_q  <= 1'b0;
                            end
                        end else begin
                            ph_q <= ph_q + PW'(1);
                        end
                    end
                    S_FIN: begin
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
`ifdef MOD_393_WATCHDOG_EN
            // Counter never matched in time: flag it and drop the interval
            if (active) begin
                wd_q <= wd_q + WDW'(1);
                if (wd_q == WD_LAST) begin
                    fault_q <= 1'b1;
                    state_q <= S_IDLE;
                    gnt_q   <= 2'b00;
                    cclr_q  <= 1'b1;
                    cclk_q  <= 1'b1;
                    done_q  <= 2'b00;
                    ph_q    <= '0;
                end
            end
`endif
        end
    end

    assign CCLK = cclk_q;
    assign CCLR = cclr_q;
    assign GNT  = gnt_q;
    assign DONE = done_q;

`ifdef MOD_393_WATCHDOG_EN
    assign FAULT = fault_q;
`else
    assign FAULT = 1'b0;
`endif

endmodule

// File: tb/tb_mod_393_interval_arbiter.sv
// Bench for mod_393_interval_arbiter with HALF=1 driving a behavioural
// 393 counter section. Expected intervals are queued when requests are
// driven and popped when the DUT completes them.

module tb_mod_393_interval_arbiter;

    localparam int unsigned HALF = 1;

    logic       CLK;
    logic       CLR;
    logic [1:0] REQ;
    logic [3:0] LEN0;
    logic [3:0] LEN1;
    logic [3:0] Q;
    logic       CCLK;
    logic       CCLR;
    logic [1:0] GNT;
    logic [1:0] DONE;
    logic       FAULT;

    logic [3:0] cnt;
    logic [3:0] last_inc;
    int         falls = 0;
    int         wraps = 0;
    logic       force_q0;

    assign Q = force_q0 ? 4'd0 : cnt;

    mod_393_interval_arbiter #(.HALF(HALF)) dut (
        .CLK   (CLK),
        .CLR   (CLR),
        .REQ   (REQ),
        .LEN0  (LEN0),
        .LEN1  (LEN1),
        .Q     (Q),
        .CCLK  (CCLK),
        .CCLR  (CCLR),
        .GNT   (GNT),
        .DONE  (DONE),
        .FAULT (FAULT)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Behavioural 393 section: async clear, counts on falling clock
    always @(negedge CCLK or posedge CCLR) begin
        if (CCLR) begin
            cnt <= 4'd0;
        end else begin
            if (cnt == 4'hF) wraps <= wraps + 1;
            cnt      <= cnt + 4'd1;
            last_inc <= cnt + 4'd1;
        end
    end

    always @(negedge CCLK) falls <= falls + 1;

    typedef struct {
        logic [1:0] mask;
        int         lat;
        int         edges;
    } exp_t;

    exp_t sb[$];

    int n_assert = 0;
    int n_fail   = 0;
    bit got;
    bit done_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic do_reset();
        CLR = 1'b1;
        REQ = 2'b00;
        tick(2);
        CLR = 1'b0;
    endtask

    task automatic push_iv(input logic [1:0] mask, input logic [3:0] len);
        exp_t e;
        e.mask  = mask;
        e.edges = (len == 4'd0) ? 16 : int'(len);
        e.lat   = 1 + 2 * int'(HALF) * e.edges;
        sb.push_back(e);
    endtask

    task automatic wait_interval(input bit scramble, input bit drop_after);
        exp_t e;
        bit   ok;
        bit   held;
        int   lat;
        int   f0;
        int   w0;
        e  = sb.pop_front();
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            tick(1);
            ok = (GNT != 2'b00);
        end
        chk("gnt_arrives", 32'(ok), 32'd1);
        chk("gnt_value", 32'(GNT), 32'(e.mask));
        f0 = falls;
        w0 = wraps;
        if (scramble) begin
            LEN0 = 4'd1;
            LEN1 = 4'd1;
        end
        held = 1'b1;
        ok   = 1'b0;
        lat  = 0;
        while (!ok && lat < 200) begin
            tick(1);
            lat++;
            if (DONE != 2'b00) ok = 1'b1;
            else if (GNT != e.mask) held = 1'b0;
        end
        if (drop_after) REQ = 2'b00;
        chk("done_arrives", 32'(ok), 32'd1);
        chk("done_value", 32'(DONE), 32'(e.mask));
        chk("gnt_to_done", 32'(lat), 32'(e.lat));
        chk("gnt_held", 32'(held), 32'd1);
        chk("gnt_clear_fin", 32'(GNT), 32'd0);
        chk("cclk_falls", 32'(falls - f0), 32'(e.edges));
        chk("last_count", 32'(last_inc), 32'(e.edges % 16));
        chk("wraps", 32'(wraps - w0), (e.edges == 16) ? 32'd1 : 32'd0);
    endtask

    initial begin
        REQ      = 2'b00;
        LEN0     = 4'd0;
        LEN1     = 4'd0;
        CLR      = 1'b1;
        force_q0 = 1'b0;
        tick(2);
        chk("rst_cclk", 32'(CCLK), 32'd1);
        chk("rst_cclr", 32'(CCLR), 32'd1);
        chk("rst_gnt", 32'(GNT), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
        chk("rst_fault", 32'(FAULT), 32'd0);
        CLR = 1'b0;

        // Single requester, length 3; length inputs change after grant
        LEN0 = 4'd3;
        REQ  = 2'b01;
        push_iv(2'b01, 4'd3);
        wait_interval(1'b1, 1'b1);
        tick(3);
        chk("idle_after_drop", 32'(GNT), 32'd0);

        // Both requesting from reset: 0 first, then 1
        do_reset();
        LEN0 = 4'd2;
        LEN1 = 4'd5;
        REQ  = 2'b11;
        push_iv(2'b01, 4'd2);
        push_iv(2'b10, 4'd5);
        wait_interval(1'b0, 1'b0);
        wait_interval(1'b0, 1'b1);
        tick(3);

        // Length 0 means 16 counts with a wrap
        LEN1 = 4'd0;
        REQ  = 2'b10;
        push_iv(2'b10, 4'd0);
        wait_interval(1'b0, 1'b1);
        tick(3);

        // Withdraw request mid-interval
        do_reset();
        LEN0 = 4'd9;
        REQ  = 2'b01;
        got  = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            tick(1);
            got = (Q == 4'd2);
        end
        chk("q_reaches_2", 32'(got), 32'd1);
        REQ = 2'b00;
        tick(1);
        chk("abort_gnt", 32'(GNT), 32'd0);
        chk("abort_cclr", 32'(CCLR), 32'd1);
        chk("abort_cclk", 32'(CCLK), 32'd1);
        chk("abort_done", 32'(DONE), 32'd0);
        done_seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick(1);
            if (DONE != 2'b00) done_seen = 1'b1;
        end
        chk("no_done_after_abort", 32'(done_seen), 32'd0);

        // Reset while in LO, then round-robin restarts at requester 0
        do_reset();
        LEN0 = 4'd5;
        LEN1 = 4'd5;
        REQ  = 2'b10;
        got  = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            tick(1);
            got = (CCLK == 1'b0);
        end
        chk("reach_lo", 32'(got), 32'd1);
        CLR = 1'b1;
        tick(1);
        chk("clr_cclk", 32'(CCLK), 32'd1);
        chk("clr_cclr", 32'(CCLR), 32'd1);
        chk("clr_gnt", 32'(GNT), 32'd0);
        chk("clr_done", 32'(DONE), 32'd0);
        CLR = 1'b0;
        REQ = 2'b11;
        tick(1);
        chk("rr_after_clr", 32'(GNT), 32'd1);
        REQ = 2'b00;
        tick(3);

        // Counter stuck at 0
        do_reset();
        force_q0 = 1'b1;
        LEN0     = 4'd4;
        REQ      = 2'b01;
        got      = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            tick(1);
            got = (GNT != 2'b00);
        end
        chk("stall_gnt", 32'(got), 32'd1);
        done_seen = 1'b0;
`ifdef MOD_393_WATCHDOG_EN
        for (int k = 1; k <= 36; k++) begin
            tick(1);
            if (DONE != 2'b00) done_seen = 1'b1;
            if (k == 35) chk("fault_before_limit", 32'(FAULT), 32'd0);
        end
        chk("fault_at_limit", 32'(FAULT), 32'd1);
        chk("wd_gnt_clear", 32'(GNT), 32'd0);
        chk("wd_no_done", 32'(done_seen), 32'd0);
        REQ = 2'b00;
        tick(5);
        chk("fault_sticky", 32'(FAULT), 32'd1);
        CLR = 1'b1;
        tick(1);
        CLR = 1'b0;
        chk("fault_cleared", 32'(FAULT), 32'd0);
`else
        for (int k = 0; k < 40; k++) begin
            tick(1);
            if (DONE != 2'b00) done_seen = 1'b1;
        end
        chk("no_fault", 32'(FAULT), 32'd0);
        chk("stall_no_done", 32'(done_seen), 32'd0);
        chk("stall_gnt_held", 32'(GNT), 32'd1);
        REQ = 2'b00;
        tick(2);
        chk("stall_release", 32'(GNT), 32'd0);
`endif
        force_q0 = 1'b0;
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mod_393_interval_arbiter.md
MOD_393_INTERVAL_ARBITER -- requirements
Module: mod_393_interval_arbiter

Interface
REQ-001 SHALL have parameter HALF, default 1, giving the CLK cycles per CCLK phase; legal range 1..8.
REQ-002 SHALL have port CLK  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port CLR  input  1  reset: synchronous, active-high.
REQ-004 SHALL have port REQ  input  2  per-requester interval request, level; bit i belongs to requester i.
REQ-005 SHALL have ports LEN0, LEN1  input  4 each  interval length in counts; 0 means 16.
REQ-006 SHALL have port Q  input  4  count readback from the external 4-bit 393-type counter section.
REQ-007 SHALL have port CCLK  output  1  count clock to the counter; the counter advances on its falling edge.
REQ-008 SHALL have port CCLR  output  1  active-high clear to the counter.
REQ-009 SHALL have port GNT  output  2  one-hot grant, held for the whole interval.
REQ-010 SHALL have port DONE  output  2  one-cycle pulse on bit i when requester i's interval completes.
REQ-011 SHALL have port FAULT  output  1  sticky watchdog flag (see Configuration).

Function
REQ-012 SHALL implement states IDLE, ARM, LO, HI, FIN; all outputs registered.
REQ-013 IDLE: CCLK=1, CCLR=1, GNT=00; if REQ!=00, pick winner, set GNT, latch its LEN as target T, go ARM.
REQ-014 Arbitration SHALL be round-robin: on REQ=11, the requester not last served wins; after reset requester 0 wins first.
REQ-015 ARM: 1 cycle, CCLR=0, CCLK=1, so the counter reads 0.
REQ-016 LO: CCLK=0 for HALF cycles (one counter increment), then go HI.
REQ-017 HI: CCLK=1 for HALF cycles; in its first cycle compare Q to T[3:0]; T=16 matches Q=0.
REQ-018 On match: go FIN after HI completes; otherwise go LO.
REQ-019 FIN: 1 cycle, DONE bit of granted requester = 1, GNT=00, CCLR=1, then IDLE.
REQ-020 Interval SHALL take exactly T falling CCLK edges; GNT-to-DONE = 1 + 2*HALF*T cycles.
REQ-021 If the granted REQ bit drops in ARM, LO or HI: go IDLE next cycle, GNT=00, CCLR=1, no DONE.
REQ-022 LEN changes after grant SHALL be ignored; a REQ held through FIN SHALL be re-arbitrated in IDLE.
REQ-023 Non-granted REQ bits SHALL not affect the active interval.

Reset
REQ-024 CLR=1 at a rising edge SHALL force IDLE, CCLK=1, CCLR=1, GNT=00, DONE=00, FAULT=0, and round-robin favouring requester 0.
REQ-025 Reset mid-interval SHALL abort with no DONE pulse; CLR dominates all other inputs.

Configuration
REQ-026 Macro MOD_393_WATCHDOG_EN defined: a cycle counter runs from ARM; with no match by 2*HALF*17+2 cycles, FAULT=1 sticky (cleared by CLR only), state goes IDLE, no DONE.
REQ-027 Macro undefined: FAULT SHALL be constant 0 and no watchdog logic is built.

Verification (HALF=1, DUT driving a behavioural 393 section)
REQ-028 REQ=01, LEN0=3 -> GNT=01 next cycle; Q steps 1,2,3; DONE=01 exactly 7 cycles after GNT rises; 3 CCLK falling edges.
REQ-029 REQ=11 from reset, LEN0=2, LEN1=5 -> requester 0 served first (DONE[0] after 5 cycles), then requester 1 (DONE[1] 11 cycles after its GNT).
REQ-030 LEN1=0 -> 16 falling edges; Q wraps 15->0; DONE[1] 33 cycles after GNT.
REQ-031 Drop REQ[0] after Q=2 with LEN0=9 -> IDLE next cycle, GNT=00, CCLR=1, DONE stays 00.
REQ-032 Assert CLR while in LO -> next cycle CCLK=1, CCLR=1, GNT=00; a following REQ=11 grants requester 0.
REQ-033 With MOD_393_WATCHDOG_EN, hold Q=0 and LEN0=4 -> FAULT=1 at cycle 36 after ARM, no DONE; FAULT stays 1 until CLR.
